// File: rtl/seq_pkg.sv
// Shared types for the serial sequence checker slice.
// Holds history width, mode encoding and checker FSM states.
package seq_pkg;

  localparam int SEQ_W = 4;

  typedef enum logic [1:0] {
    MODE0,
    MODE1,
    MODE2,
    MODE_OFF
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HUNT,
    LOCK
  } state_t;

endpackage

// File: rtl/seq_predict.sv
// Feedback equations of the 4-bit sequence family.
// Ports: h (history, h[0] newest), mode, p (next bit).
module seq_predict
  import seq_pkg::*;
(
  input  logic [SEQ_W-1:0] h,
  input  mode_t            mode,
  output logic             p
);

  always_comb begin
    p = 1'b0;
    case (mode)
      MODE0:   p = ~(h[0] | h[1] | h[2]);
      MODE1:   p = ~h[3] | (~h[2] & ~h[1] & h[0]);
      MODE2:   p = ~h[3] | (h[2] & ~h[1] & ~h[0]);
      default: p = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_checker.sv
// Serial checker: fills history, hunts for lock, then flywheels.
// Ports: clk, rst, mode, din, din_valid, locked, err, err_cnt.
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_N   = 8,
  parameter int UNLOCK_N = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] LOCK_V   = 8'(LOCK_N);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_N);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_n;
  logic [SEQ_W-1:0] h_q, h_d;
  logic [2:0]       raw_q, raw_d;
  logic [1:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_d, err_d;
  logic [CNT_W-1:0] cnt_d;
  logic             p;

  assign mode_n = mode_t'(mode);

  seq_predict u_pred (
    .h    (h_q),
    .mode (mode_n),
    .p    (p)
  );

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    raw_d    = raw_q;
    fill_d   = fill_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked;
    err_d    = 1'b0;
    cnt_d    = err_cnt;
    if (mode_n != mode_q) begin
      state_d  = (mode_n == MODE_OFF) ? IDLE : FILL;
      h_d      = '0;
      raw_d    = '0;
      fill_d   = '0;
      match_d  = '0;
      miss_d   = '0;
      locked_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A valid mode with no change seen (e.g. mode 0
          // straight out of reset) still needs to start.
          if (mode_n != MODE_OFF) state_d = FILL;
        end
        FILL: begin
          if (din_valid) begin
            h_d    = {h_q[2:0], din};
            raw_d  = {raw_q[1:0], din};
            fill_d = fill_q + 2'd1;
            if (fill_q == 2'd3) state_d = HUNT;
          end
        end
        HUNT: begin
          if (din_valid) begin
            h_d   = {h_q[2:0], din};
            raw_d = {raw_q[1:0], din};
            if (din == p) begin
              match_d = match_q + 8'd1;
              if (match_q + 8'd1 == LOCK_V) begin
                state_d  = LOCK;
                locked_d = 1'b1;
                miss_d   = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCK: begin
          if (din_valid) begin
            // Flywheel: history follows the prediction.
            h_d   = {h_q[2:0], p};
            raw_d = {raw_q[1:0], din};
            if (din != p) begin
              err_d  = 1'b1;
              miss_d = miss_q + 4'd1;
              if (err_cnt != '1) cnt_d = err_cnt + 1'b1;
              if (miss_q + 4'd1 == UNLOCK_V) begin
                state_d  = HUNT;
                locked_d = 1'b0;
                match_d  = '0;
                h_d      = {raw_q, din};
              end
            end else begin
              miss_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE0;
      h_q     <= '0;
      raw_q   <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_n;
      h_q     <= h_d;
      raw_q   <= raw_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      locked  <= locked_d;
      err     <= err_d;
      err_cnt <= cnt_d;
    end
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Serial receiver and checker for the 4-bit shift-register sequence generator family (modes 0–2).
- Self-synchronises to the incoming bit stream by filling a local 4-bit history, then predicting each next bit from the same feedback equations and comparing it with the received bit.
- Declares lock after a run of correct predictions, then counts bit errors with flywheel behaviour.
- Sits at the far end of the serial link, opposite the generator.

Parameters:
- LOCK_N, 8: consecutive matches in HUNT required to enter LOCK (1..255).
- UNLOCK_N, 3: consecutive mismatches in LOCK that force a return to HUNT (1..15).
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  sequence select: 0, 1, 2 valid; 3 invalid, block idles.
- din  in  1  received serial bit.
- din_valid  in  1  din is sampled on cycles where this is 1.
- locked  out  1  registered; 1 while in LOCK.
- err  out  1  registered; one-cycle pulse per mismatched bit while in LOCK.
- err_cnt  out  CNT_W  saturating count of err pulses since the last clear.

Behaviour:
- History H[3:0]: on each accepted bit, H <= {H[2:0], b}. H[0] is the newest bit, H[3] the oldest.
- Predicted bit p (combinational on H and mode):
  - mode 0: p = ~(H0|H1|H2)
  - mode 1: p = ~H3 | (~H2&~H1&H0)
  - mode 2: p = ~H3 | (H2&~H1&~H0)
  - mode 3: p = 0, unused.
- Reset: state=IDLE; H=0; fill_cnt=0; match_cnt=0; miss_cnt=0; locked=0; err=0; err_cnt=0.
- Mode tracking: mode_q is registered every cycle. If mode != mode_q, this is a mode change:
  - clear H, fill_cnt, match_cnt, miss_cnt and err_cnt; locked=0.
  - next state is IDLE if the new mode is 3, otherwise FILL.
  - a din_valid arriving in the same cycle is discarded.
- IDLE: entered when mode==3. din is ignored and all outputs are held at their cleared values.
- FILL: each valid bit shifts din into H and increments fill_cnt. After the 4th bit, go to HUNT. No comparison is made in FILL.
- HUNT: each valid bit compares din with p, then shifts din into H.
  - Match: match_cnt++. When match_cnt reaches LOCK_N, go to LOCK, set locked=1 on the next edge and clear miss_cnt.
  - Mismatch: match_cnt=0. No err pulse and no err_cnt change.
- LOCK (flywheel): each valid bit shifts p into H, not din, so a single bit error does not corrupt the prediction.
  - Mismatch: err=1 for exactly the next cycle, err_cnt++ (saturates at 2^CNT_W-1) and miss_cnt++. When miss_cnt reaches UNLOCK_N, go to HUNT, set locked=0, clear match_cnt, and load H from the last 4 received bits. The received bits are kept in a separate raw shift register.
  - Match: miss_cnt=0.
- Latency: err and locked update on the clock edge that samples the deciding bit, so they are visible in the following cycle.
- din_valid=0: no state change, err=0.
- Reset mid-operation: identical to power-on reset on the next edge; any in-flight err pulse is cancelled.
- err_cnt is cleared only by rst or a mode change.

Decomposition:
- Package seq_pkg:
  - SEQ_W=4.
  - mode_t enum: MODE0, MODE1, MODE2, MODE_OFF.
  - state_t enum: IDLE, FILL, HUNT, LOCK.
- Sub-module seq_predict: combinational, inputs H[3:0] and mode, output p. It is the single definition of the feedback equations and is reusable by a future generator rewrite.
- The FSM, counters and raw shift register live in seq_checker.

Test Plan:
- Reset check: assert rst for 2 cycles with mode=1 → locked=0, err=0, err_cnt=0. State is FILL after release because mode_q resets to 0 and mode=1 counts as a mode change.
- Mode 1 lock: mode=1, stream 11110000 repeated 3 times with din_valid=1 every cycle → locked rises the cycle after the 12th bit (4 fill + 8 matches). err stays 0 and err_cnt=0.
- Single error while locked: invert one bit → err pulses for exactly 1 cycle, err_cnt=1, locked stays 1. The next 16 correct bits produce no err.
- Loss of lock: invert 3 consecutive bits while locked → err pulses 3 times, err_cnt=3, locked=0 after the 3rd. Resuming the correct stream relocks after 8 matching bits.
- Mode switch mid-lock: change to mode=2 → locked=0 and err_cnt=0 next cycle. Stream 01101001 repeated, preceded by the fill bits 1001 → locked after 12 bits.
- Idle and saturation:
  - mode=3 with random din for 20 cycles → outputs stay 0.
  - With CNT_W=2, force 5 mismatches while locked and UNLOCK_N=15 → err_cnt saturates at 3.
